// File: rtl/cache_controller_pkg.sv
// Shared definitions for the cache sequencing controller: store control codes,
// FSM state encoding, word/block widths and the block word-select helper.
package cache_controller_pkg;

  localparam int WORD_W  = 13;
  localparam int BLOCK_W = 3 * WORD_W;

  typedef enum logic [1:0] {
    CC_IDLE  = 2'b00,
    CC_READ  = 2'b01,
    CC_WRITE = 2'b10,
    CC_PULL  = 2'b11
  } cc_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MISS_REQ = 3'd2,
    S_FILL     = 3'd3,
    S_WR_MEM   = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  // Offset 3 never reaches a fetch, so it maps to zero.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         k);
    logic [WORD_W-1:0] w;
    case (k)
      2'd0:    w = blk[WORD_W-1:0];
      2'd1:    w = blk[2*WORD_W-1:WORD_W];
      2'd2:    w = blk[3*WORD_W-1:2*WORD_W];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU, cache-store and main-memory signals of the cache controller.
// Handshakes: cpu_req is held until the one-cycle cpu_ready pulse; mem_req is held until the one-cycle mem_ack.
interface cache_controller_if
  import cache_controller_pkg::*;
#(
  parameter int ADDR_W = 10
) ();
  logic                cpu_req;
  logic                cpu_we;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [WORD_W-1:0]   cpu_wdata;
  logic                cpu_ready;
  logic [WORD_W-1:0]   cpu_rdata;
  logic                cpu_err;
  logic [1:0]          cache_ctrl;
  logic [2:0]          cache_index;
  logic [1:0]          cache_offset;
  logic [WORD_W-1:0]   cache_wdata;
  logic [WORD_W-1:0]   cache_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [BLOCK_W-1:0]  mem_block;
  logic [2:0]          state_dbg;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_rdata, mem_ack, mem_block,
    output cpu_ready, cpu_rdata, cpu_err, cache_ctrl, cache_index, cache_offset,
           cache_wdata, mem_req, mem_we, mem_addr, mem_wdata, state_dbg
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_rdata, mem_ack, mem_block,
    input  cpu_ready, cpu_rdata, cpu_err, cache_ctrl, cache_index, cache_offset,
           cache_wdata, mem_req, mem_we, mem_addr, mem_wdata, state_dbg
  );
endinterface

// File: rtl/cache_tag_store.sv
// 8-entry key/valid array for the direct-mapped cache; key = {tag, offset}.
// Valid bits clear synchronously on rst; hit is combinational on the current index/key.
module cache_tag_store #(
  parameter int KEY_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       index,
  input  logic [KEY_W-1:0] key,
  input  logic             fill_en,
  output logic             hit
);
  logic [7:0]       valid_q, valid_d;
  logic [KEY_W-1:0] key_q [8];
  logic [KEY_W-1:0] key_d [8];

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    if (fill_en) begin
      valid_d[index] = 1'b1;
      key_d[index]   = key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
    key_q <= key_d;
  end

  assign hit = valid_q[index] && (key_q[index] == key);
endmodule

// File: rtl/cache_controller.sv
// Cache sequencing controller: tag lookup, miss fill over mem req/ack, write-through without allocate.
// Defining CACHE_CTRL_STATS_EN adds saturating read hit/miss counters.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic rst,
  cache_controller_if.master bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int KEY_W = ADDR_W - 3;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, err_q, err_d;
  logic [WORD_W-1:0] wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
  logic              hit, fill_en;
  logic [2:0]        index;
  logic [1:0]        offset;
  logic [KEY_W-1:0]  key;
  cc_e               cc;

  assign index  = addr_q[4:2];
  assign offset = addr_q[1:0];
  assign key    = {addr_q[ADDR_W-1:5], offset};

  cache_tag_store #(.KEY_W(KEY_W)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .index   (index),
    .key     (key),
    .fill_en (fill_en),
    .hit     (hit)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    err_d           = err_q;
    word_d          = word_q;
    rdata_d         = rdata_q;
    fill_en         = 1'b0;
    cc              = CC_IDLE;
    bus.cache_wdata = '0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.cpu_ready   = 1'b0;
    bus.cpu_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          err_d   = (bus.cpu_addr[1:0] == 2'b11);
          state_d = (bus.cpu_addr[1:0] == 2'b11) ? S_RESP : S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!we_q) begin
          if (hit) begin
            cc      = CC_READ;
            rdata_d = bus.cache_rdata;
            state_d = S_RESP;
          end else begin
            state_d = S_MISS_REQ;
          end
        end else begin
          // Write misses bypass the store entirely: no allocate.
          if (hit) begin
            cc              = CC_WRITE;
            bus.cache_wdata = wdata_q;
          end
          state_d = S_WR_MEM;
        end
      end
      S_MISS_REQ: begin
        cc           = CC_PULL;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (bus.mem_ack) begin
          word_d  = block_word(bus.mem_block, offset);
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        cc              = CC_WRITE;
        bus.cache_wdata = word_q;
        fill_en         = 1'b1;
        rdata_d         = word_q;
        state_d         = S_RESP;
      end
      S_WR_MEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        if (bus.mem_ack) state_d = S_RESP;
      end
      S_RESP: begin
        bus.cpu_ready = 1'b1;
        bus.cpu_err   = err_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.cache_ctrl   = cc;
  assign bus.cache_index  = index;
  assign bus.cache_offset = offset;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.state_dbg    = state_q;

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP && !we_q) begin
      if (hit && hit_cnt_q != 16'hFFFF)   hit_cnt_d  = hit_cnt_q + 16'd1;
      if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule
